// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants and types for the seven-segment scan
//               controller. Segment patterns are {g,f,e,d,c,b,a}, active low.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl_if
// Description : Bundle between the score logic and the scan controller.
//               master : score side (drives digits, reads display pins)
//               slave  : scan controller
//   digits_bcd  digit i value in [4i+3:4i], digit 0 rightmost
//   dp_in       decimal point request per digit (1 = lit)
//   digit_en    per-digit enable
//   lz_blank    suppress leading zeros
//   an_n/seg_n/dp_n  active-low display drives
//   digit_idx   digit currently owning the slot
//   frame_start one-cycle pulse at the first cycle of the digit 0 slot
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_ctrl_if;
    import seg_pkg::*;

    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] digits_bcd;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    lz_blank;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [6:0]              seg_n;
    logic                    dp_n;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_start;

    modport master (
        output digits_bcd, dp_in, digit_en, lz_blank,
        input  an_n, seg_n, dp_n, digit_idx, frame_start
    );

    modport slave (
        input  digits_bcd, dp_in, digit_en, lz_blank,
        output an_n, seg_n, dp_n, digit_idx, frame_start
    );

endinterface
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational 4-bit code to active-low segment pattern.
//               0-9 digits, 10 dash, 11-15 blank.
//   code   in  4  digit code
//   seg_n  out 7  {g,f,e,d,c,b,a}, active low
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        if (code <= 4'd9) begin
            seg_n = SEG_DIGIT[code];
        end else if (code == 4'd10) begin
            seg_n = SEG_DASH;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Time-multiplexed scan controller for an 8-digit seven-segment
//               display. Each digit owns a slot of DIV cycles whose first
//               BLANK_CYCLES cycles keep every anode off (anti-ghosting).
//               Inputs are snapshotted once per frame so a frame never tears.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of seg_scan_ctrl_if (inputs + display drives)
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int SLOT_HZ      = 1_000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_scan_ctrl_if.slave  bus
);

    localparam int DIV   = CLK_HZ / SLOT_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] c_cnt_last   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_idx_last   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t             r_state;
    scan_state_t             w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;

    logic [4*NUM_DIGITS-1:0] r_snap_bcd;
    logic [NUM_DIGITS-1:0]   r_snap_dp;
    logic [NUM_DIGITS-1:0]   r_snap_en;
    logic                    r_snap_lz;

    logic [NUM_DIGITS-1:0]   r_an_n;
    logic [6:0]              r_seg_n;
    logic                    r_dp_n;
    logic                    r_frame_start;

    logic                    w_cnt_last;
    logic                    w_frame_wrap;
    logic [3:0]              w_code;
    logic [6:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic                    w_visible;
    logic [NUM_DIGITS-1:0]   w_an_nxt;
    logic [6:0]              w_seg_nxt;
    logic                    w_dp_nxt;

    assign w_cnt_last   = (r_cnt == c_cnt_last);
    assign w_frame_wrap = w_cnt_last && (r_idx == c_idx_last);

    // Digit i is a leading zero when it and every higher digit are zero.
    // Digit 0 is never suppressed, so the mask bit stays clear.
    always_comb begin : p_lz_mask
        logic zero_run;
        zero_run  = 1'b1;
        w_lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run && (r_snap_bcd[4*i +: 4] == 4'd0);
            w_lz_mask[i] = r_snap_lz && zero_run;
        end
    end

    assign w_code    = r_snap_bcd[{r_idx, 2'b00} +: 4];
    assign w_visible = r_snap_en[r_idx] && !w_lz_mask[r_idx];

    seg7_decode u_decode (
        .code  (w_code),
        .seg_n (w_seg)
    );

    // Next state plus next output values. Outputs are registered from the
    // next state so they change on the same edge as the state itself.
    always_comb begin
        w_state_nxt = r_state;
        w_an_nxt    = '1;
        w_seg_nxt   = SEG_BLANK;
        w_dp_nxt    = 1'b1;
        case (r_state)
            ST_BLANK: if (r_cnt == c_blank_last) w_state_nxt = ST_DRIVE;
            ST_DRIVE: if (w_cnt_last)            w_state_nxt = ST_BLANK;
            default:                             w_state_nxt = ST_BLANK;
        endcase
        if ((w_state_nxt == ST_DRIVE) && w_visible) begin
            w_an_nxt  = ~(NUM_DIGITS'(1) << r_idx);
            w_seg_nxt = w_seg;
            w_dp_nxt  = ~r_snap_dp[r_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BLANK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The enable snapshot resets to all-ones so the first frame after reset
    // shows the all-zero snapshot as "0" digits instead of a dark display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_snap_bcd    <= '0;
            r_snap_dp     <= '0;
            r_snap_en     <= '1;
            r_snap_lz     <= 1'b0;
            r_an_n        <= '1;
            r_seg_n       <= SEG_BLANK;
            r_dp_n        <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
            if (w_cnt_last) begin
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end
            if (w_frame_wrap) begin
                r_snap_bcd <= bus.digits_bcd;
                r_snap_dp  <= bus.dp_in;
                r_snap_en  <= bus.digit_en;
                r_snap_lz  <= bus.lz_blank;
            end
            r_frame_start <= w_frame_wrap;
            r_an_n        <= w_an_nxt;
            r_seg_n       <= w_seg_nxt;
            r_dp_n        <= w_dp_nxt;
        end
    end

    assign bus.an_n        = r_an_n;
    assign bus.seg_n       = r_seg_n;
    assign bus.dp_n        = r_dp_n;
    assign bus.digit_idx   = r_idx;
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Directed self-checking bench for seg_scan_ctrl with
//               DIV = 10 cycles per slot and 2 blank cycles per slot.
//               Cycle 0 is the clock period in which reset is released.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    logic [7:0] e_an  [8];
    logic [6:0] e_seg [8];
    logic       e_dp  [8];

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(
        .CLK_HZ       (1000),
        .SLOT_HZ      (100),
        .BLANK_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_inputs(input logic [31:0] b, input logic [7:0] d,
                              input logic [7:0] e, input logic l);
        bus.digits_bcd = b;
        bus.dp_in      = d;
        bus.digit_en   = e;
        bus.lz_blank   = l;
    endtask

    // Expect every digit to show "0" without decimal point.
    task automatic expect_all_zero();
        for (int i = 0; i < 8; i++) begin
            e_an[i]  = ~(8'd1 << i);
            e_seg[i] = 7'h40;
            e_dp[i]  = 1'b1;
        end
    endtask

    // Runs one 80-cycle frame starting just after a frame boundary, checking
    // every cycle against e_an/e_seg/e_dp. At k == chg_at the inputs change.
    task automatic run_frame(input string name, input int chg_at,
                             input logic [31:0] nb, input logic [7:0] nd,
                             input logic [7:0] ne, input logic nl);
        for (int k = 1; k <= 80; k++) begin
            int cnt;
            int idx;
            tick();
            cnt = k % 10;
            idx = (k / 10) % 8;
            check($sformatf("%s fs k=%0d", name, k), 32'(bus.frame_start), 32'(k == 80));
            check($sformatf("%s idx k=%0d", name, k), 32'(bus.digit_idx), 32'(idx));
            if (cnt < 2) begin
                check($sformatf("%s blank_an k=%0d", name, k), 32'(bus.an_n), 32'h FF);
                check($sformatf("%s blank_seg k=%0d", name, k), 32'(bus.seg_n), 32'h7F);
                check($sformatf("%s blank_dp k=%0d", name, k), 32'(bus.dp_n), 32'h1);
            end else begin
                check($sformatf("%s an k=%0d", name, k), 32'(bus.an_n), 32'(e_an[idx]));
                if (e_an[idx] != 8'hFF) begin
                    check($sformatf("%s seg k=%0d", name, k), 32'(bus.seg_n), 32'(e_seg[idx]));
                    check($sformatf("%s dp k=%0d", name, k), 32'(bus.dp_n), 32'(e_dp[idx]));
                end else begin
                    check($sformatf("%s dark_dp k=%0d", name, k), 32'(bus.dp_n), 32'h1);
                end
            end
            if (k == chg_at) set_inputs(nb, nd, ne, nl);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        set_inputs(32'h0, 8'h00, 8'h00, 1'b0);

        // Reset state
        #12;
        check("rst an_n", 32'(bus.an_n), 32'hFF);
        check("rst seg_n", 32'(bus.seg_n), 32'h7F);
        check("rst dp_n", 32'(bus.dp_n), 32'h1);
        check("rst idx", 32'(bus.digit_idx), 32'h0);
        check("rst fs", 32'(bus.frame_start), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 0: all-zero snapshot; load 1234 with leading-zero blanking mid-frame
        expect_all_zero();
        run_frame("f0", 35, 32'h0000_1234, 8'h00, 8'hFF, 1'b1);

        // Frame 1: 4,3,2,1 on digits 0-3, digits 4-7 dark; change value at idx 3
        e_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        e_seg = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        e_dp  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        run_frame("f1", 35, 32'h0000_5678, 8'h00, 8'hFF, 1'b1);

        // Frame 2: new value 5678 appears
        e_seg = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        run_frame("f2", 50, 32'h0000_0000, 8'h01, 8'hFD, 1'b0);

        // Frame 3: digit 1 disabled, digit 0 shows "0."
        e_an  = '{8'hFE, 8'hFF, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        e_seg = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        e_dp  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        run_frame("f3", 50, 32'h0000_00DA, 8'h00, 8'hFF, 1'b0);

        // Frame 4: dash on digit 0, code 13 blank pattern on digit 1
        e_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        e_seg = '{7'h3F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        e_dp  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        run_frame("f4", 0, 32'h0000_00DA, 8'h00, 8'hFF, 1'b0);

        // Async reset in the middle of the digit 0 drive window (cnt 5)
        repeat (5) tick();
        check("pre-rst an_n", 32'(bus.an_n), 32'hFE);
        check("pre-rst seg_n", 32'(bus.seg_n), 32'h3F);
        #2;
        rst_n = 1'b0;
        #1;
        check("async an_n", 32'(bus.an_n), 32'hFF);
        check("async seg_n", 32'(bus.seg_n), 32'h7F);
        check("async dp_n", 32'(bus.dp_n), 32'h1);
        check("async idx", 32'(bus.digit_idx), 32'h0);
        check("async fs", 32'(bus.frame_start), 32'h0);
        tick();
        check("held an_n", 32'(bus.an_n), 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;

        // Timing restarts at cnt 0 / idx 0 with the all-zero snapshot
        expect_all_zero();
        run_frame("post", 0, 32'h0000_00DA, 8'h00, 8'hFF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
